vend_multi_ctrl: RTL and testbench

//  Parametrised vending controller: N products, per-product price table and stock counters, credit accumulator.

---
 rtl/vend_pkg.sv | 34 +++
 rtl/vend_multi_ctrl_if.sv | 45 ++++
 rtl/vend_coin_decode.sv | 19 +
 rtl/vend_multi_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_vend_multi_ctrl.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and helpers for the multi-product vending controller:
// FSM state encoding, error codes and the coin code to value mapping.
package vend_pkg;

   localparam int COIN_CODE_W = 3;
   localparam int COIN_VAL_W  = 5;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_COLLECT = 3'd1,
      S_VEND    = 3'd2,
      S_CHANGE  = 3'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_NONE      = 2'd0,
      ERR_SOLD_OUT  = 2'd1,
      ERR_NO_CREDIT = 2'd2,
      ERR_BAD_IDX   = 2'd3
   } err_t;

   // A zero return marks an invalid code; no real coin is worth nothing.
   function automatic logic [COIN_VAL_W-1:0] coin_value(input logic [COIN_CODE_W-1:0] code);
      case (code)
         3'd1:    return 5'd1;
         3'd2:    return 5'd2;
         3'd3:    return 5'd5;
         3'd4:    return 5'd10;
         3'd5:    return 5'd20;
         default: return 5'd0;
      endcase
   endfunction

endpackage

// File: rtl/vend_multi_ctrl_if.sv
// Front-end / dispenser / hopper signal bundle of the vending controller.
// The controller takes the slave side; the front end and drivers the master side.
interface vend_multi_ctrl_if #(
   parameter int NUM_ITEMS = 4,
   parameter int SEL_W     = 2,
   parameter int PRICE_W   = 8,
   parameter int STOCK_W   = 4
);

   logic                         coin_valid;
   logic [2:0]                   coin_code;
   logic                         coin_accept;
   logic                         coin_reject;
   logic                         sel_valid;
   logic [SEL_W-1:0]             sel;
   logic                         cancel;
   logic [NUM_ITEMS*PRICE_W-1:0] price_flat;
   logic                         restock_valid;
   logic [SEL_W-1:0]             restock_idx;
   logic [STOCK_W-1:0]           restock_qty;
   logic                         vend_valid;
   logic [SEL_W-1:0]             vend_idx;
   logic                         vend_ack;
   logic                         change_valid;
   logic [PRICE_W-1:0]           change_amt;
   logic                         change_ack;
   logic [PRICE_W-1:0]           credit;
   logic [1:0]                   err;
   logic [2:0]                   state;

   modport slave (
      input  coin_valid, coin_code, sel_valid, sel, cancel, price_flat,
             restock_valid, restock_idx, restock_qty, vend_ack, change_ack,
      output coin_accept, coin_reject, vend_valid, vend_idx, change_valid,
             change_amt, credit, err, state
   );

   modport master (
      output coin_valid, coin_code, sel_valid, sel, cancel, price_flat,
             restock_valid, restock_idx, restock_qty, vend_ack, change_ack,
      input  coin_accept, coin_reject, vend_valid, vend_idx, change_valid,
             change_amt, credit, err, state
   );

endinterface

// File: rtl/vend_coin_decode.sv
// Combinational coin decoder: maps the acceptor's code to a credit value
// widened to the price datapath, plus a flag for recognised codes.
module vend_coin_decode
   import vend_pkg::*;
#(
   parameter int PRICE_W = 8
) (
   input  logic [COIN_CODE_W-1:0] code,
   output logic [PRICE_W-1:0]     value,
   output logic                   valid
);

   logic [COIN_VAL_W-1:0] raw;

   assign raw   = coin_value(code);
   assign value = PRICE_W'(raw);
   assign valid = (raw != '0);

endmodule

// File: rtl/vend_multi_ctrl.sv
// Multi-product vending controller: credit accumulator, per-item stock and
// price lookup, and valid/ack handshakes towards dispenser and change hopper.
module vend_multi_ctrl
   import vend_pkg::*;
#(
   parameter int NUM_ITEMS  = 4,
   parameter int SEL_W      = 2,
   parameter int PRICE_W    = 8,
   parameter int STOCK_W    = 4,
   parameter int MAX_CREDIT = 200
) (
   input  logic             clk,
   input  logic             reset,
   vend_multi_ctrl_if.slave bus
);

   localparam logic [SEL_W:0]   NUM_ITEMS_C  = (SEL_W+1)'(NUM_ITEMS);
   localparam logic [PRICE_W:0] MAX_CREDIT_C = (PRICE_W+1)'(MAX_CREDIT);

   state_t               state_q, state_d;
   logic [PRICE_W-1:0]   credit_q, credit_d;
   logic [PRICE_W-1:0]   change_amt_q, change_amt_d;
   logic                 change_valid_q, change_valid_d;
   logic                 vend_valid_q, vend_valid_d;
   logic [SEL_W-1:0]     vend_idx_q, vend_idx_d;
   logic                 coin_accept_q, coin_accept_d;
   logic                 coin_reject_q, coin_reject_d;
   err_t                 err_q, err_d;

   logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
   logic [PRICE_W-1:0]   price_tab [NUM_ITEMS];

   for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_price
      assign price_tab[i] = bus.price_flat[i*PRICE_W +: PRICE_W];
   end

   // ---------------------------------------------------------------- coins
   logic [PRICE_W-1:0] coin_val;
   logic               coin_ok;
   logic [PRICE_W:0]   coin_sum;

   vend_coin_decode #(.PRICE_W(PRICE_W)) u_coin_decode (
      .code  (bus.coin_code),
      .value (coin_val),
      .valid (coin_ok)
   );

   assign coin_sum = {1'b0, credit_q} + {1'b0, coin_val};

   // ---------------------------------------------------------------- events
   // cancel only has meaning in COLLECT; elsewhere it must not mask lower strobes.
   logic in_entry, do_cancel, do_select, do_coin, coin_credit;
   logic vend_done, change_done;

   assign in_entry    = (state_q == S_IDLE) || (state_q == S_COLLECT);
   assign do_cancel   = bus.cancel && (state_q == S_COLLECT);
   assign do_select   = bus.sel_valid && in_entry && !do_cancel;
   assign do_coin     = bus.coin_valid && in_entry && !do_cancel && !bus.sel_valid;
   assign coin_credit = do_coin && coin_ok && (coin_sum <= MAX_CREDIT_C);
   assign vend_done   = (state_q == S_VEND) && bus.vend_ack && vend_valid_q;
   assign change_done = (state_q == S_CHANGE) && bus.change_ack && change_valid_q;

   // ---------------------------------------------------------------- selection checks
   logic               sel_bad, restock_bad;
   logic [SEL_W-1:0]   sel_idx;
   logic [STOCK_W-1:0] sel_stock;
   logic [PRICE_W-1:0] sel_price;
   err_t               sel_err;
   logic               sel_go;

   assign sel_bad     = ({1'b0, bus.sel} >= NUM_ITEMS_C);
   assign restock_bad = ({1'b0, bus.restock_idx} >= NUM_ITEMS_C);
   assign sel_idx     = sel_bad ? '0 : bus.sel;
   assign sel_stock   = stock_q[sel_idx];
   assign sel_price   = price_tab[sel_idx];

   always_comb begin
      if (sel_bad)                     sel_err = ERR_BAD_IDX;
      else if (sel_stock == '0)        sel_err = ERR_SOLD_OUT;
      else if (credit_q < sel_price)   sel_err = ERR_NO_CREDIT;
      else                             sel_err = ERR_NONE;
   end

   // A clean selection in IDLE only reports; dispensing needs COLLECT.
   assign sel_go = do_select && (sel_err == ERR_NONE) && (state_q == S_COLLECT);

   // ---------------------------------------------------------------- FSM state register
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // ---------------------------------------------------------------- FSM next state
   // NOTE: default assignment first keeps every path driven, so no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:    if (coin_credit) state_d = S_COLLECT;
         S_COLLECT: begin
            if (do_cancel)   state_d = S_CHANGE;
            else if (sel_go) state_d = S_VEND;
         end
         S_VEND:    if (vend_done) state_d = (credit_q != '0) ? S_CHANGE : S_IDLE;
         S_CHANGE:  if (change_done) state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- FSM outputs
   always_comb begin
      credit_d       = credit_q;
      change_amt_d   = change_amt_q;
      change_valid_d = change_valid_q;
      vend_valid_d   = vend_valid_q;
      vend_idx_d     = vend_idx_q;
      err_d          = err_q;
      coin_accept_d  = coin_credit;
      coin_reject_d  = bus.coin_valid && !coin_credit;

      // err holds the outcome of the most recent strobe.
      if (bus.coin_valid || bus.sel_valid || bus.cancel) err_d = ERR_NONE;
      if (do_select) err_d = sel_err;

      if (coin_credit) credit_d = coin_sum[PRICE_W-1:0];

      if (sel_go) begin
         credit_d     = credit_q - sel_price;
         vend_valid_d = 1'b1;
         vend_idx_d   = bus.sel;
      end

      if (do_cancel) begin
         change_amt_d   = credit_q;
         change_valid_d = 1'b1;
         credit_d       = '0;
      end

      if (vend_done) begin
         vend_valid_d = 1'b0;
         if (credit_q != '0) begin
            change_amt_d   = credit_q;
            change_valid_d = 1'b1;
            credit_d       = '0;
         end
      end

      if (change_done) begin
         change_valid_d = 1'b0;
         change_amt_d   = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         credit_q       <= '0;
         change_amt_q   <= '0;
         change_valid_q <= 1'b0;
         vend_valid_q   <= 1'b0;
         vend_idx_q     <= '0;
         coin_accept_q  <= 1'b0;
         coin_reject_q  <= 1'b0;
         err_q          <= ERR_NONE;
      end else begin
         credit_q       <= credit_d;
         change_amt_q   <= change_amt_d;
         change_valid_q <= change_valid_d;
         vend_valid_q   <= vend_valid_d;
         vend_idx_q     <= vend_idx_d;
         coin_accept_q  <= coin_accept_d;
         coin_reject_q  <= coin_reject_d;
         err_q          <= err_d;
      end
   end

   // ---------------------------------------------------------------- stock counters
   // NOTE: the stock array is reset because an empty machine must report sold-out;
   // a plain storage RAM would normally be left unreset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_ITEMS; i++) stock_q[i] <= '0;
      end else if ((state_q == S_IDLE) && bus.restock_valid && !restock_bad) begin
         stock_q[bus.restock_idx] <= bus.restock_qty;
      end else if (sel_go) begin
         stock_q[sel_idx] <= sel_stock - 1'b1;
      end
   end

   // ---------------------------------------------------------------- outputs
   assign bus.coin_accept  = coin_accept_q;
   assign bus.coin_reject  = coin_reject_q;
   assign bus.vend_valid   = vend_valid_q;
   assign bus.vend_idx     = vend_idx_q;
   assign bus.change_valid = change_valid_q;
   assign bus.change_amt   = change_amt_q;
   assign bus.credit       = credit_q;
   assign bus.err          = err_q;
   assign bus.state        = state_q;

endmodule

// File: tb/tb_vend_multi_ctrl.sv
// Directed bench for vend_multi_ctrl: three products so that an out-of-range
// selector is representable, hand-computed expectations after every strobe.
module tb_vend_multi_ctrl;

   localparam int NUM_ITEMS  = 3;
   localparam int SEL_W      = 2;
   localparam int PRICE_W    = 8;
   localparam int STOCK_W    = 4;
   localparam int MAX_CREDIT = 200;

   localparam logic [2:0] C5  = 3'd3;
   localparam logic [2:0] C10 = 3'd4;
   localparam logic [2:0] C20 = 3'd5;
   localparam logic [2:0] C1  = 3'd1;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   vend_multi_ctrl_if #(
      .NUM_ITEMS(NUM_ITEMS), .SEL_W(SEL_W), .PRICE_W(PRICE_W), .STOCK_W(STOCK_W)
   ) bus ();

   vend_multi_ctrl #(
      .NUM_ITEMS(NUM_ITEMS), .SEL_W(SEL_W), .PRICE_W(PRICE_W),
      .STOCK_W(STOCK_W), .MAX_CREDIT(MAX_CREDIT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic coin(input logic [2:0] code);
      @(negedge clk);
      bus.coin_valid = 1'b1;
      bus.coin_code  = code;
      tick();
      bus.coin_valid = 1'b0;
   endtask

   task automatic select(input logic [SEL_W-1:0] s);
      @(negedge clk);
      bus.sel_valid = 1'b1;
      bus.sel       = s;
      tick();
      bus.sel_valid = 1'b0;
   endtask

   task automatic cancel_req();
      @(negedge clk);
      bus.cancel = 1'b1;
      tick();
      bus.cancel = 1'b0;
   endtask

   task automatic ack_vend();
      @(negedge clk);
      bus.vend_ack = 1'b1;
      tick();
      bus.vend_ack = 1'b0;
   endtask

   task automatic ack_change();
      @(negedge clk);
      bus.change_ack = 1'b1;
      tick();
      bus.change_ack = 1'b0;
   endtask

   task automatic restock(input logic [SEL_W-1:0] idx, input logic [STOCK_W-1:0] qty);
      @(negedge clk);
      bus.restock_valid = 1'b1;
      bus.restock_idx   = idx;
      bus.restock_qty   = qty;
      tick();
      bus.restock_valid = 1'b0;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_state"},   32'(bus.state),        32'd0);
      check({tag, "_credit"},  32'(bus.credit),       32'd0);
      check({tag, "_err"},     32'(bus.err),          32'd0);
      check({tag, "_vvalid"},  32'(bus.vend_valid),   32'd0);
      check({tag, "_vidx"},    32'(bus.vend_idx),     32'd0);
      check({tag, "_cvalid"},  32'(bus.change_valid), 32'd0);
      check({tag, "_camt"},    32'(bus.change_amt),   32'd0);
      check({tag, "_accept"},  32'(bus.coin_accept),  32'd0);
      check({tag, "_reject"},  32'(bus.coin_reject),  32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset             = 1'b0;
      bus.coin_valid    = 1'b0;
      bus.coin_code     = '0;
      bus.sel_valid     = 1'b0;
      bus.sel           = '0;
      bus.cancel        = 1'b0;
      bus.restock_valid = 1'b0;
      bus.restock_idx   = '0;
      bus.restock_qty   = '0;
      bus.vend_ack      = 1'b0;
      bus.change_ack    = 1'b0;
      // item0 = 30, item1 = 15, item2 = 15
      bus.price_flat    = {8'd15, 8'd15, 8'd30};

      repeat (3) tick();
      check_reset_outputs("rst");
      @(negedge clk);
      reset = 1'b1;

      restock(2'd0, 4'd2);
      restock(2'd1, 4'd3);

      // Test 1: 10+10+5, buy item1 at 15, change 10
      coin(C10);
      check("t1_accept", 32'(bus.coin_accept), 32'd1);
      check("t1_credit10", 32'(bus.credit), 32'd10);
      check("t1_collect", 32'(bus.state), 32'd1);
      coin(C10);
      coin(C5);
      check("t1_credit25", 32'(bus.credit), 32'd25);
      tick();
      check("t1_accept_pulse", 32'(bus.coin_accept), 32'd0);
      select(2'd1);
      check("t1_vvalid", 32'(bus.vend_valid), 32'd1);
      check("t1_vidx", 32'(bus.vend_idx), 32'd1);
      check("t1_credit_after", 32'(bus.credit), 32'd10);
      check("t1_state_vend", 32'(bus.state), 32'd2);
      tick();
      check("t1_vvalid_held", 32'(bus.vend_valid), 32'd1);
      ack_vend();
      check("t1_vvalid_drop", 32'(bus.vend_valid), 32'd0);
      check("t1_cvalid", 32'(bus.change_valid), 32'd1);
      check("t1_camt", 32'(bus.change_amt), 32'd10);
      check("t1_credit0", 32'(bus.credit), 32'd0);
      check("t1_state_change", 32'(bus.state), 32'd3);
      tick();
      check("t1_camt_held", 32'(bus.change_amt), 32'd10);
      ack_change();
      check("t1_cvalid_drop", 32'(bus.change_valid), 32'd0);
      check("t1_idle", 32'(bus.state), 32'd0);

      // stray ack with no request pending
      ack_vend();
      check("stray_ack_state", 32'(bus.state), 32'd0);
      check("stray_ack_vvalid", 32'(bus.vend_valid), 32'd0);

      // Test 2: credit 5 < 15, then cancel refund
      coin(C5);
      select(2'd1);
      check("t2_err", 32'(bus.err), 32'd2);
      check("t2_credit", 32'(bus.credit), 32'd5);
      check("t2_state", 32'(bus.state), 32'd1);
      check("t2_no_vend", 32'(bus.vend_valid), 32'd0);
      tick();
      check("t2_err_sticky", 32'(bus.err), 32'd2);
      cancel_req();
      check("t2_cvalid", 32'(bus.change_valid), 32'd1);
      check("t2_camt", 32'(bus.change_amt), 32'd5);
      check("t2_err_clear", 32'(bus.err), 32'd0);
      ack_change();
      check("t2_idle", 32'(bus.state), 32'd0);

      // Test 3: sold-out item2, then bad index
      coin(C20);
      select(2'd2);
      check("t3_err_sold", 32'(bus.err), 32'd1);
      check("t3_no_vend", 32'(bus.vend_valid), 32'd0);
      check("t3_credit", 32'(bus.credit), 32'd20);
      select(2'(NUM_ITEMS));
      check("t3_err_idx", 32'(bus.err), 32'd3);
      check("t3_state", 32'(bus.state), 32'd1);
      cancel_req();
      check("t3_camt", 32'(bus.change_amt), 32'd20);
      ack_change();

      // Test 4: credit ceiling and invalid code
      for (int i = 0; i < 9; i++) coin(C20);
      coin(C10);
      check("t4_credit190", 32'(bus.credit), 32'd190);
      coin(C20);
      check("t4_reject", 32'(bus.coin_reject), 32'd1);
      check("t4_no_accept", 32'(bus.coin_accept), 32'd0);
      check("t4_credit_kept", 32'(bus.credit), 32'd190);
      coin(3'd6);
      check("t4_reject_code6", 32'(bus.coin_reject), 32'd1);
      check("t4_credit_kept6", 32'(bus.credit), 32'd190);
      coin(C10);
      check("t4_accept_at_max", 32'(bus.coin_accept), 32'd1);
      check("t4_credit200", 32'(bus.credit), 32'd200);

      // Test 5: cancel + select + coin together
      @(negedge clk);
      bus.cancel     = 1'b1;
      bus.sel_valid  = 1'b1;
      bus.sel        = 2'd0;
      bus.coin_valid = 1'b1;
      bus.coin_code  = C1;
      tick();
      bus.cancel     = 1'b0;
      bus.sel_valid  = 1'b0;
      bus.coin_valid = 1'b0;
      check("t5_reject", 32'(bus.coin_reject), 32'd1);
      check("t5_cvalid", 32'(bus.change_valid), 32'd1);
      check("t5_camt", 32'(bus.change_amt), 32'd200);
      check("t5_no_vend", 32'(bus.vend_valid), 32'd0);
      check("t5_state", 32'(bus.state), 32'd3);
      ack_change();

      // item1 stock left after test 1 must be 2: two sales, then sold out
      for (int i = 0; i < 2; i++) begin
         coin(C20);
         select(2'd1);
         check("dep_vend", 32'(bus.vend_valid), 32'd1);
         ack_vend();
         check("dep_camt", 32'(bus.change_amt), 32'd5);
         ack_change();
      end
      coin(C20);
      select(2'd1);
      check("dep_sold_out", 32'(bus.err), 32'd1);
      cancel_req();
      ack_change();

      // exact payment: no change, straight back to IDLE
      coin(C20);
      coin(C10);
      select(2'd0);
      check("exact_credit0", 32'(bus.credit), 32'd0);
      ack_vend();
      check("exact_no_change", 32'(bus.change_valid), 32'd0);
      check("exact_idle", 32'(bus.state), 32'd0);

      // Test 6: reset while vend_valid is high
      coin(C20);
      coin(C10);
      select(2'd0);
      check("t6_in_vend", 32'(bus.vend_valid), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check_reset_outputs("t6");
      @(negedge clk);
      reset = 1'b1;

      // stock was cleared by reset
      coin(C20);
      select(2'd1);
      check("post_rst_sold", 32'(bus.err), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
